// File: rtl/regfile_ctrl_pkg.sv
// Shared encodings and default widths for the register file sequencing controller.
// Used by regfile_ctrl and regfile_ctrl_arb.
package regfile_ctrl_pkg;

    localparam int DEF_NREQ   = 2;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_RD  = 2'd0,
        OP_WR  = 2'd1,
        OP_CLR = 2'd2
    } op_t;

    // Width of a requester index; NREQ is limited to 2..4.
    function automatic int idx_width(input int n);
        return (n > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/regfile_ctrl_arb.sv
// Combinational requester arbiter: one-hot grant plus grant index.
// REGFILE_CTRL_RR_EN selects round-robin from last_idx; otherwise lowest index wins.
module regfile_ctrl_arb
    import regfile_ctrl_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int IDX_W = idx_width(DEF_NREQ)
) (
    input  logic [NREQ-1:0]  req_valid,
`ifdef REGFILE_CTRL_RR_EN
    input  logic [IDX_W-1:0] last_idx,
`endif
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx
);

`ifdef REGFILE_CTRL_RR_EN
    logic [IDX_W-1:0] cand;

    // Walk the search order backwards so the earliest candidate overwrites the rest.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_idx) + k) % NREQ);
            if (req_valid[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end
`else
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/regfile_ctrl.sv
// Sequencing controller/arbiter for the 16 x 32-bit register file command port.
// Define REGFILE_CTRL_RR_EN for round-robin arbitration (default: fixed priority).
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*ADDR_W-1:0]   req_addr_b,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     clr_req,
    output logic                     clr_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata_a,
    output logic [DATA_W-1:0]        rsp_rdata_b,
    output logic                     rf_en,
    output logic                     rf_rd,
    output logic                     rf_wr,
    output logic                     rf_rst,
    output logic [ADDR_W-1:0]        rf_sel_i,
    output logic [ADDR_W-1:0]        rf_sel_o1,
    output logic [ADDR_W-1:0]        rf_sel_o2,
    output logic [DATA_W-1:0]        rf_wdata,
    input  logic [DATA_W-1:0]        rf_rdata_a,
    input  logic [DATA_W-1:0]        rf_rdata_b,
    output logic                     busy
);

    localparam int IDX_W = idx_width(NREQ);

    state_t             state;
    op_t                op;
    logic [IDX_W-1:0]   win_idx;
    logic [NREQ-1:0]    grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [DATA_W-1:0]  hold_a;
    logic [DATA_W-1:0]  hold_b;
    logic               idle;
    logic               win_we;
    logic [ADDR_W-1:0]  win_addr;
    logic [ADDR_W-1:0]  win_addr_b;
    logic [DATA_W-1:0]  win_wdata;

`ifdef REGFILE_CTRL_RR_EN
    logic [IDX_W-1:0]   last_idx;
`endif

    regfile_ctrl_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_valid (req_valid),
`ifdef REGFILE_CTRL_RR_EN
        .last_idx  (last_idx),
`endif
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Gating with rst_n keeps the acceptance pulses low while reset is held.
    assign idle       = rst_n && (state == IDLE);
    assign clr_ready  = idle && clr_req;
    assign req_ready  = (idle && !clr_req) ? grant : '0;

    assign win_we     = req_we[grant_idx];
    assign win_addr   = req_addr[int'(grant_idx) * ADDR_W +: ADDR_W];
    assign win_addr_b = req_addr_b[int'(grant_idx) * ADDR_W +: ADDR_W];
    assign win_wdata  = req_wdata[int'(grant_idx) * DATA_W +: DATA_W];

    // The file's read data arrives during RESP; outside a read response the last read is held.
    assign rsp_rdata_a = (state == RESP && op == OP_RD) ? rf_rdata_a : hold_a;
    assign rsp_rdata_b = (state == RESP && op == OP_RD) ? rf_rdata_b : hold_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= OP_RD;
            win_idx   <= '0;
            rf_en     <= 1'b0;
            rf_rd     <= 1'b0;
            rf_wr     <= 1'b0;
            rf_rst    <= 1'b0;
            rf_sel_i  <= '0;
            rf_sel_o1 <= '0;
            rf_sel_o2 <= '0;
            rf_wdata  <= '0;
            rsp_valid <= '0;
            busy      <= 1'b0;
            hold_a    <= '0;
            hold_b    <= '0;
`ifdef REGFILE_CTRL_RR_EN
            last_idx  <= IDX_W'(NREQ - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (clr_ready) begin
                        op     <= OP_CLR;
                        rf_en  <= 1'b1;
                        rf_rst <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ISSUE;
                    end else if (|req_ready) begin
                        win_idx <= grant_idx;
                        op      <= win_we ? OP_WR : OP_RD;
                        rf_en   <= 1'b1;
                        rf_wr   <= win_we;
                        rf_rd   <= !win_we;
                        if (win_we) begin
                            rf_sel_i <= win_addr;
                            rf_wdata <= win_wdata;
                        end else begin
                            rf_sel_o1 <= win_addr;
                            rf_sel_o2 <= win_addr_b;
                        end
`ifdef REGFILE_CTRL_RR_EN
                        last_idx <= grant_idx;
`endif
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    rf_en     <= 1'b0;
                    rf_rd     <= 1'b0;
                    rf_wr     <= 1'b0;
                    rf_rst    <= 1'b0;
                    rf_sel_i  <= '0;
                    rf_sel_o1 <= '0;
                    rf_sel_o2 <= '0;
                    rf_wdata  <= '0;
                    if (op != OP_CLR) begin
                        rsp_valid <= NREQ'(1) << win_idx;
                    end
                    state <= RESP;
                end
                RESP: begin
                    rsp_valid <= '0;
                    if (op == OP_RD) begin
                        hold_a <= rf_rdata_a;
                        hold_b <= rf_rdata_b;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: behavioural register file, transaction-level reference model,
// directed table, multi-cycle corner sequences and randomized commands.
`timescale 1ns/1ps
module tb_regfile_ctrl;

    localparam int NREQ   = 2;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*ADDR_W-1:0] req_addr_b;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_ready;
    logic                   clr_req;
    logic                   clr_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata_a;
    logic [DATA_W-1:0]      rsp_rdata_b;
    logic                   rf_en, rf_rd, rf_wr, rf_rst;
    logic [ADDR_W-1:0]      rf_sel_i, rf_sel_o1, rf_sel_o2;
    logic [DATA_W-1:0]      rf_wdata;
    logic [DATA_W-1:0]      rf_rdata_a = '0;
    logic [DATA_W-1:0]      rf_rdata_b = '0;
    logic                   busy;

    logic [NREQ-1:0]        a_we;
    logic [ADDR_W-1:0]      a_addr  [NREQ];
    logic [ADDR_W-1:0]      a_addrb [NREQ];
    logic [DATA_W-1:0]      a_wdata [NREQ];

    assign req_we     = a_we;
    assign req_addr   = {a_addr[1], a_addr[0]};
    assign req_addr_b = {a_addrb[1], a_addrb[0]};
    assign req_wdata  = {a_wdata[1], a_wdata[0]};

    regfile_ctrl #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_addr_b(req_addr_b), .req_wdata(req_wdata), .req_ready(req_ready),
        .clr_req(clr_req), .clr_ready(clr_ready),
        .rsp_valid(rsp_valid), .rsp_rdata_a(rsp_rdata_a), .rsp_rdata_b(rsp_rdata_b),
        .rf_en(rf_en), .rf_rd(rf_rd), .rf_wr(rf_wr), .rf_rst(rf_rst),
        .rf_sel_i(rf_sel_i), .rf_sel_o1(rf_sel_o1), .rf_sel_o2(rf_sel_o2),
        .rf_wdata(rf_wdata), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the 16 x 32 register file: synchronous write/clear, registered read.
    logic [DATA_W-1:0] rf_mem [16] = '{default: '0};
    always @(posedge clk) begin
        if (rf_en && rf_rst) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
        end else if (rf_en && rf_wr) begin
            rf_mem[rf_sel_i] <= rf_wdata;
        end
        if (rf_en && rf_rd) begin
            rf_rdata_a <= rf_mem[rf_sel_o1];
            rf_rdata_b <= rf_mem[rf_sel_o2];
        end
    end

    logic [DATA_W-1:0] model_mem [16];
    int                rr_last;
    logic [DATA_W-1:0] hold_a, hold_b;
    int                vectors = 0;
    int                miscompares = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int expWinner(input logic [NREQ-1:0] v);
`ifdef REGFILE_CTRL_RR_EN
        for (int k = 1; k <= NREQ; k++)
            if (v[(rr_last + k) % NREQ]) return (rr_last + k) % NREQ;
`else
        for (int i = 0; i < NREQ; i++)
            if (v[i]) return i;
`endif
        return -1;
    endfunction

    // One full command: wait for acceptance, then check ISSUE, RESP and return to IDLE.
    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic clr,
                                 output logic [31:0] got_a, output logic [31:0] got_b);
        int w;
        int cnt;
        logic is_wr;
        logic [NREQ-1:0] oh;
        logic [31:0] ea, eb;
        got_a = '0;
        got_b = '0;
        @(posedge clk); #1;
        req_valid = valid;
        clr_req   = clr;
        cnt = 0;
        @(negedge clk);
        while (req_ready == '0 && !clr_ready && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 10) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: got no ready expected acceptance");
            req_valid = '0;
            clr_req   = 1'b0;
            return;
        end
        oh = '0;
        if (clr) begin
            w = 0;
            checkOutput("clr_ready", clr_ready, 1);
            checkOutput("req_ready_under_clr", req_ready, 0);
        end else begin
            w = expWinner(valid);
            oh[w] = 1'b1;
            checkOutput("req_ready", req_ready, oh);
            checkOutput("clr_ready_idle", clr_ready, 0);
        end
        is_wr = !clr && a_we[w];
        ea = model_mem[a_addr[w]];
        eb = model_mem[a_addrb[w]];
        @(posedge clk); #1;
        req_valid = '0;
        clr_req   = 1'b0;
        @(negedge clk);
        checkOutput("busy_issue", busy, 1);
        checkOutput("rf_en_issue", rf_en, 1);
        checkOutput("rf_rst_issue", rf_rst, clr);
        checkOutput("rf_wr_issue", rf_wr, is_wr);
        checkOutput("rf_rd_issue", rf_rd, !clr && !is_wr);
        if (is_wr) begin
            checkOutput("rf_sel_i", rf_sel_i, a_addr[w]);
            checkOutput("rf_wdata", rf_wdata, a_wdata[w]);
        end else if (!clr) begin
            checkOutput("rf_sel_o1", rf_sel_o1, a_addr[w]);
            checkOutput("rf_sel_o2", rf_sel_o2, a_addrb[w]);
        end
        if (clr) begin
            for (int i = 0; i < 16; i++) model_mem[i] = '0;
        end else begin
            if (is_wr) model_mem[a_addr[w]] = a_wdata[w];
            rr_last = w;
        end
        @(negedge clk);
        checkOutput("rsp_valid_resp", rsp_valid, oh);
        checkOutput("rf_en_resp", rf_en, 0);
        checkOutput("rf_rst_resp", rf_rst, 0);
        if (!clr && !is_wr) begin
            hold_a = ea;
            hold_b = eb;
        end
        checkOutput("rsp_rdata_a", rsp_rdata_a, hold_a);
        checkOutput("rsp_rdata_b", rsp_rdata_b, hold_b);
        got_a = rsp_rdata_a;
        got_b = rsp_rdata_b;
        @(negedge clk);
        checkOutput("busy_done", busy, 0);
        checkOutput("rsp_valid_done", rsp_valid, 0);
    endtask

    typedef struct {
        int               req;
        logic             we;
        logic [3:0]       addr;
        logic [3:0]       addr_b;
        logic [31:0]      wdata;
        logic [31:0]      exp_a;
        logic [31:0]      exp_b;
    } vec_t;

    vec_t             tbl [8];
    logic [NREQ-1:0]  v;
    logic [NREQ-1:0]  oh;
    logic [31:0]      ga, gb;
    logic             clr;
    int               w;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0] = '{0, 1'b1, 4'd5,  4'd0,  32'hDEADBEEF, 32'h0,        32'h0};
        tbl[1] = '{0, 1'b0, 4'd5,  4'd0,  32'h0,        32'hDEADBEEF, 32'h0};
        tbl[2] = '{1, 1'b1, 4'd0,  4'd0,  32'h12345678, 32'h0,        32'h0};
        tbl[3] = '{1, 1'b0, 4'd0,  4'd5,  32'h0,        32'h12345678, 32'hDEADBEEF};
        tbl[4] = '{0, 1'b1, 4'd15, 4'd0,  32'hFFFFFFFF, 32'h0,        32'h0};
        tbl[5] = '{1, 1'b0, 4'd15, 4'd15, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
        tbl[6] = '{0, 1'b1, 4'd5,  4'd0,  32'h00000001, 32'h0,        32'h0};
        tbl[7] = '{0, 1'b0, 4'd5,  4'd0,  32'h0,        32'h00000001, 32'h12345678};

        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        rr_last   = NREQ - 1;
        hold_a    = '0;
        hold_b    = '0;
        req_valid = '0;
        clr_req   = 1'b0;
        a_we      = '0;
        for (int r = 0; r < NREQ; r++) begin
            a_addr[r] = '0; a_addrb[r] = '0; a_wdata[r] = '0;
        end

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_rf_en", rf_en, 0);
        checkOutput("reset_rf_cmd", {rf_rd, rf_wr, rf_rst}, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rdata_a", rsp_rdata_a, 0);
        checkOutput("reset_ready", {req_ready, clr_ready}, 0);
        rst_n = 1'b1;

        $display("[TB] directed table");
        for (int i = 0; i < 8; i++) begin
            a_we[tbl[i].req]    = tbl[i].we;
            a_addr[tbl[i].req]  = tbl[i].addr;
            a_addrb[tbl[i].req] = tbl[i].addr_b;
            a_wdata[tbl[i].req] = tbl[i].wdata;
            v = '0;
            v[tbl[i].req] = 1'b1;
            applyStimulus(v, 1'b0, ga, gb);
            if (!tbl[i].we) begin
                checkOutput("tbl_rdata_a", ga, tbl[i].exp_a);
                checkOutput("tbl_rdata_b", gb, tbl[i].exp_b);
            end
        end

        $display("[TB] clear priority");
        a_we[1] = 1'b0; a_addr[1] = 4'd5; a_addrb[1] = 4'd15;
        applyStimulus(2'b10, 1'b1, ga, gb);
        applyStimulus(2'b10, 1'b0, ga, gb);
        checkOutput("clr_read5", ga, 0);
        checkOutput("clr_read15", gb, 0);

        $display("[TB] withdrawn request");
        @(posedge clk); #1;
        a_we[0] = 1'b1; a_addr[0] = 4'd7; a_wdata[0] = 32'h0BADF00D;
        a_we[1] = 1'b1; a_addr[1] = 4'd8; a_wdata[1] = 32'h11111111;
        req_valid = 2'b01;
        @(negedge clk);
        checkOutput("wd_accept", req_ready, 2'b01);
        rr_last = 0;
        @(posedge clk); #1;
        req_valid = 2'b10;
        @(negedge clk);
        checkOutput("wd_ready_busy", req_ready, 0);
        checkOutput("wd_sel_i", rf_sel_i, 7);
        checkOutput("wd_wdata", rf_wdata, 32'h0BADF00D);
        model_mem[7] = 32'h0BADF00D;
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checkOutput("wd_rsp_valid", rsp_valid, 2'b01);
        repeat (2) begin
            @(negedge clk);
            checkOutput("wd_no_rf", {rf_en, rf_wr}, 0);
            checkOutput("wd_no_ready", req_ready, 0);
            checkOutput("wd_idle", busy, 0);
        end

        $display("[TB] mid-operation reset");
        @(posedge clk); #1;
        a_we[0] = 1'b1; a_addr[0] = 4'd3; a_wdata[0] = 32'hAAAA5555;
        req_valid = 2'b01;
        @(negedge clk);
        checkOutput("rst_accept", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_rf_lines", {rf_en, rf_rd, rf_wr, rf_rst}, 0);
        checkOutput("rst_rf_sel_i", rf_sel_i, 0);
        checkOutput("rst_rf_wdata", rf_wdata, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_busy", busy, 0);
        rr_last = NREQ - 1;
        hold_a  = '0;
        hold_b  = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy_after", busy, 0);
        checkOutput("rst_rsp_after", rsp_valid, 0);

        $display("[TB] contention");
        @(posedge clk); #1;
        a_we = 2'b00;
        a_addr[0] = 4'd3; a_addrb[0] = 4'd7;
        a_addr[1] = 4'd5; a_addrb[1] = 4'd0;
        req_valid = 2'b11;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c % 3 == 0) begin
                w = expWinner(2'b11);
                oh = '0;
                oh[w] = 1'b1;
                checkOutput("cont_grant", req_ready, oh);
                rr_last = w;
                hold_a = model_mem[a_addr[w]];
                hold_b = model_mem[a_addrb[w]];
            end else begin
                checkOutput("cont_gap", req_ready, 0);
            end
        end
        @(posedge clk); #1;
        req_valid = '0;

        $display("[TB] randomized commands");
        for (int n = 0; n < 60; n++) begin
            for (int r = 0; r < NREQ; r++) begin
                a_we[r]    = 1'($urandom_range(0, 1));
                a_addr[r]  = 4'($urandom_range(0, 15));
                a_addrb[r] = 4'($urandom_range(0, 15));
                a_wdata[r] = $urandom;
            end
            clr = ($urandom_range(0, 9) == 0);
            v   = 2'($urandom_range(1, 3));
            applyStimulus(v, clr, ga, gb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Sequencing controller and arbiter for the 16 x 32-bit register file. Multiplexes NREQ requesters and one clear source onto the register file's single command port (RD/WR/EN/rst/selects), and issues the file's one-cycle-delayed read data back to the winning requester as a tagged response. Sits between the register file and its clients; the register file itself is not modified.

## Interface
- NREQ, 2: number of requesters, 2..4
- DATA_W, 32: data width
- ADDR_W, 4: register select width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*ADDR_W  write select or read select A, packed with requester 0 in the LSBs
- req_addr_b  in  NREQ*ADDR_W  read select B, packed
- req_wdata  in  NREQ*DATA_W  write data, packed
- req_ready  out  NREQ  one-hot acceptance pulse
- clr_req  in  1  request to clear all registers
- clr_ready  out  1  clear accepted
- rsp_valid  out  NREQ  one-hot completion pulse
- rsp_rdata_a  out  DATA_W  read data A
- rsp_rdata_b  out  DATA_W  read data B
- rf_en, rf_rd, rf_wr, rf_rst  out  1 each  register file command lines
- rf_sel_i, rf_sel_o1, rf_sel_o2  out  ADDR_W  register file selects
- rf_wdata  out  DATA_W  register file write data
- rf_rdata_a, rf_rdata_b  in  DATA_W  register file Op1/Op2
- busy  out  1  high when the state is not IDLE

## Operation
- FSM states:
  - IDLE: accepts requests.
  - ISSUE: drives one register file command for exactly one cycle.
  - RESP: pulses the completion for one cycle, then returns to IDLE.
- Acceptance happens only in IDLE, and at most one command is accepted per cycle.
- clr_req has absolute priority. When clr_req and any req_valid are high together in IDLE, the controller sets clr_ready=1 and all req_ready=0.
- Requester grant uses the policy set in Configuration. req_ready[g] is combinational and is high only in IDLE.
- Requesters must hold valid and all fields stable until they see ready. Dropping valid before ready is legal and means the request is withdrawn.
- On acceptance, the controller latches the winner index, the operation, the selects and the write data into registered rf_* outputs.
- Register file commands during ISSUE (all other rf_* command lines are 0 in every other state):
  - Write: rf_en=1, rf_wr=1, rf_rd=0.
  - Read: rf_en=1, rf_rd=1, rf_wr=0, with sel_o1 from addr and sel_o2 from addr_b.
  - Clear: rf_en=1, rf_rst=1.
- Behaviour in RESP:
  - rsp_valid[g]=1 for reads and writes.
  - For reads, rsp_rdata_a and rsp_rdata_b pass rf_rdata_a and rf_rdata_b through. They are valid only while rsp_valid is high.
  - For writes, rsp_rdata_* holds its previous value.
  - Clear produces no rsp_valid.
- No response backpressure: the requester must sample in the RESP cycle.

## Timing
- Reset values: all outputs 0, state IDLE, round-robin pointer 0 (last-granted = NREQ-1, so requester 0 wins first).
- Accept edge E0 → ISSUE during cycle 1 → RESP during cycle 2 → IDLE during cycle 3.
- Read latency: 2 cycles from acceptance to rsp_valid.
- Throughput: one command per 3 cycles.
- Read data A/B are the register contents as of the ISSUE edge.
- Read-after-write to the same register from back-to-back commands returns the new value.
- rst_n asserted in any state aborts the command immediately:
  - rf_* lines and rsp_valid drop asynchronously.
  - No response is produced.
  - After deassertion, the state is IDLE.
- busy is registered and equals (state != IDLE).

## Configuration
- REGFILE_CTRL_RR_EN defined: round-robin arbitration.
  - The search starts at the index after the last granted requester and wraps from NREQ-1 to 0.
  - The pointer updates only on a requester grant, not on a clear.
- REGFILE_CTRL_RR_EN undefined: fixed priority, lowest index wins. The pointer register is not generated.

## Structure
- Shared package regfile_ctrl_pkg holds:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2)
  - op encoding (OP_RD, OP_WR, OP_CLR)
  - default widths
- One sub-module, regfile_ctrl_arb: combinational grant from req_valid plus pointer, producing a one-hot grant and a grant index. It contains both policies under the macro.

## Test plan
- Write then read: req0 writes 0xDEADBEEF to reg 5, then reads addr=5 and addr_b=0. Required: req_ready at E0, rf_wr in cycle 1, rsp_valid[0] in cycle 2; for the read, rsp_rdata_a=0xDEADBEEF and rsp_rdata_b=0.
- Contention, with REGFILE_CTRL_RR_EN: req0 and req1 valid continuously. Required grants 0,1,0,1, each 3 cycles apart. Without the macro: grants 0,0,0.
- Clear priority: clr_req together with req1 valid. Required: clr_ready=1, req_ready=0, rf_rst high one cycle. A following read of reg 5 returns 0, and req1 is then granted.
- Withdrawn request: req_valid[1] pulses high for one cycle while the controller is busy. Required: no grant and no rf activity for requester 1.
- Mid-operation reset: rst_n low during ISSUE of a write to reg 3. Required: all outputs 0 immediately, no rsp_valid, busy=0 after release, and the next grant goes to requester 0.
